// File: rtl/scan_data_reg_if.sv
// scan_data_reg_if: controller decode, serial and parallel data signals of the scan data register
// master drives the controller state lines (reset/shift/update/run), si and par_in
// slave is the register itself and drives so, par_out, upd_valid and err
interface scan_data_reg_if #(parameter int WIDTH = 8);
    logic             reset;
    logic             shift;
    logic             update;
    logic             run;
    logic             si;
    logic [WIDTH-1:0] par_in;
    logic             so;
    logic [WIDTH-1:0] par_out;
    logic             upd_valid;
    logic             err;
    modport master (output reset, shift, update, run, si, par_in,
                    input  so, par_out, upd_valid, err);
    modport slave  (input  reset, shift, update, run, si, par_in,
                    output so, par_out, upd_valid, err);
endinterface

// File: rtl/scan_data_reg.sv
// scan_data_reg: serial scan data register following the test controller's decoded states
// clk : rising-edge clock
// rs  : synchronous active-low reset
// bus : slave side of scan_data_reg_if (reset/shift/update/run/si/par_in in, so/par_out/upd_valid/err out)
module scan_data_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic           clk,
    input logic           rs,
    scan_data_reg_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             shift_d, update_d;
    // run and the all-low pattern need no branch: falling through the
    // priority chain below holds every register except upd_valid
    always_ff @(posedge clk) begin
        if (!rs || bus.reset) begin
            sr            <= '0;
            cnt           <= '0;
            bus.so        <= 1'b0;
            bus.par_out   <= RESET_VAL;
            bus.upd_valid <= 1'b0;
            bus.err       <= 1'b0;
            shift_d       <= 1'b0;
            update_d      <= 1'b0;
        end else begin
            shift_d       <= bus.shift;
            update_d      <= bus.update;
            bus.upd_valid <= 1'b0;
            if (bus.update && !update_d) begin
                cnt <= '0;
                if (cnt == FULL) begin
                    bus.par_out   <= sr;
                    bus.upd_valid <= 1'b1;
                    bus.err       <= 1'b0;
                end else begin
                    bus.err <= 1'b1;
                end
            end else if (bus.shift && !shift_d) begin
                // first shift cycle: par_in[0] goes straight out, the rest is loaded behind it
                sr     <= {bus.si, bus.par_in[WIDTH-1:1]};
                bus.so <= bus.par_in[0];
                cnt    <= CW'(1);
            end else if (bus.shift) begin
                sr     <= {bus.si, sr[WIDTH-1:1]};
                bus.so <= sr[0];
                cnt    <= (cnt == FULL) ? cnt : cnt + CW'(1);
            end
        end
    end
endmodule
